// File: rtl/imem_loader_if.sv
// imem_loader_if: the loader's byte-stream input and its instruction-memory write bus.
//   s_valid/s_data/s_ready : byte stream into the loader (valid/ready handshake)
//   mem_we/mem_addr/mem_wdata : byte write port toward instruction memory
// The slave modport is the loader's view; the master modport is the
// producer/observer side (stream source, memory).
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport slave  (input  s_valid, s_data, output s_ready, mem_we, mem_addr, mem_wdata);
  modport master (output s_valid, s_data, input  s_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader writing the byte-wide instruction memory.
// Frame = COUNT byte N, 4*N data bytes (stored little-endian from addr 0),
// then a CHK byte equal to the 8-bit sum of the data bytes. The CPU is held
// until a frame completes with a good checksum.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   start_i          : pulse, begin a new frame (honoured in IDLE/DONE/ERR)
//   bus (slave)      : byte stream in, memory write port out
//   cpu_hold_o       : 1 = CPU must not fetch
//   done_o / err_o   : last frame accepted / rejected
//   words_loaded_o   : word count of the last accepted frame
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  imem_loader_if.slave    bus,
  output logic            cpu_hold_o,
  output logic            done_o,
  output logic            err_o,
  output logic [5:0]      words_loaded_o
);
  localparam int BL_W = $clog2(4*MAX_WORDS+1);

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR} state_e;

  state_e            state_q, state_d;
  logic              s_ready_q, mem_we_q, cpu_hold_q, done_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q, addr_q;
  logic [7:0]        mem_wdata_q, sum_q;
  logic [BL_W-1:0]   bytes_left_q;
  logic [5:0]        n_q, words_loaded_q;
  logic              accept;

  assign accept = bus.s_valid & s_ready_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_i) state_d = S_COUNT;
      S_COUNT: if (accept) begin
        if (bus.s_data == 8'd0 || int'(bus.s_data) > MAX_WORDS) state_d = S_ERR;
        else                                                    state_d = S_DATA;
      end
      S_DATA:  if (accept && bytes_left_q == BL_W'(1)) state_d = S_CHECK;
      S_CHECK: if (accept) state_d = (bus.s_data == sum_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      s_ready_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= '0;
      sum_q          <= '0;
      addr_q         <= '0;
      bytes_left_q   <= '0;
      n_q            <= '0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CHECK);
      cpu_hold_q <= (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
      // Write port trails the accepting edge by one cycle.
      mem_we_q   <= accept && (state_q == S_DATA);

      if (accept && state_q == S_COUNT) begin
        n_q          <= bus.s_data[5:0];
        bytes_left_q <= BL_W'({bus.s_data, 2'b00});
        addr_q       <= '0;
        sum_q        <= '0;
      end

      if (accept && state_q == S_DATA) begin
        mem_addr_q   <= addr_q;
        mem_wdata_q  <= bus.s_data;
        addr_q       <= addr_q + ADDR_W'(1);
        sum_q        <= sum_q + bus.s_data;
        bytes_left_q <= bytes_left_q - BL_W'(1);
      end

      if (state_q == S_CHECK && state_d == S_DONE) words_loaded_q <= n_q;
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign cpu_hold_o      = cpu_hold_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign words_loaded_o  = words_loaded_q;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 32;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n, start_i;
  logic       cpu_hold_o, done_o, err_o;
  logic [5:0] words_loaded_o;

  imem_loader_if #(.ADDR_W(ADDR_W)) bif ();

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .bus            (bif),
    .cpu_hold_o     (cpu_hold_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  wr_t        exp_q[$];
  bit         mon_en = 0;
  bit         cur_is_data = 0;
  bit         exp_we = 0;
  logic [7:0] wr_addr = 0;
  logic [7:0] last_addr = 0;
  logic [5:0] exp_words = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] d[$]);
    logic [7:0] s = 0;
    foreach (d[i]) s += d[i];
    return s;
  endfunction

  // A write is due the cycle after any data byte the loader took.
  always @(posedge clk)
    exp_we <= rst_n && bif.s_valid && bif.s_ready && cur_is_data;

  // Monitor: every write must be expected, in order, at the expected address.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mem_we", {31'd0, bif.mem_we}, {31'd0, exp_we});
      if (bif.mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, bif.mem_addr}, {24'd0, e.addr});
          chk("wr_data", {24'd0, bif.mem_wdata}, {24'd0, e.data});
          last_addr = bif.mem_addr;
        end
      end
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 valid every other cycle, 2 random idle cycles.
  task automatic send_byte(input logic [7:0] b, input bit is_data, input int gap, input bit pulse);
    int g, t;
    bit acc;
    g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
    bif.s_valid = 1'b0;
    repeat (g) @(posedge clk);
    if (g > 0) #1;
    bif.s_valid = 1'b1;
    bif.s_data  = b;
    cur_is_data = is_data;
    start_i     = pulse;
    t   = 0;
    acc = 0;
    while (!acc) begin
      @(posedge clk);
      if (bif.s_ready === 1'b1) acc = 1;
      else if (++t > 50) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    if (acc && is_data) begin
      exp_q.push_back({wr_addr, b});
      wr_addr++;
    end
    #1;
    bif.s_valid = 1'b0;
    cur_is_data = 0;
    start_i     = 1'b0;
  endtask

  task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
    chk({tag, "_done"},  {31'd0, done_o},     {31'd0, exp_done});
    chk({tag, "_err"},   {31'd0, err_o},      {31'd0, exp_err});
    chk({tag, "_hold"},  {31'd0, cpu_hold_o}, {31'd0, !exp_done});
    chk({tag, "_words"}, {26'd0, words_loaded_o}, {26'd0, exp_words});
    chk({tag, "_ready"}, {31'd0, bif.s_ready}, 32'd0);
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] cnt, input logic [7:0] d[$],
                           input logic [7:0] chkb, input int gap, input int start_at);
    bit ok_cnt, good;
    ok_cnt = (cnt != 0) && (int'(cnt) <= MAX_WORDS);
    pulse_start();
    wr_addr = 0;
    send_byte(cnt, 0, gap, 0);
    if (ok_cnt) begin
      foreach (d[i]) send_byte(d[i], 1, gap, i == start_at);
      send_byte(chkb, 0, gap, 0);
    end
    good = ok_cnt && (chkb == sum8(d));
    if (good) exp_words = cnt[5:0];
    @(negedge clk);
    check_status(tag, good, !good);
  endtask

  task automatic apply_reset_and_check();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    exp_words = 0;
    chk("rst_ready", {31'd0, bif.s_ready}, 32'd0);
    chk("rst_we",    {31'd0, bif.mem_we}, 32'd0);
    chk("rst_addr",  {24'd0, bif.mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, bif.mem_wdata}, 32'd0);
    chk("rst_hold",  {31'd0, cpu_hold_o}, 32'd1);
    chk("rst_done",  {31'd0, done_o}, 32'd0);
    chk("rst_err",   {31'd0, err_o}, 32'd0);
    chk("rst_words", {26'd0, words_loaded_o}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1[$], ff[$], rd[$], none[$];
    logic [7:0] n, c;

    rst_n = 1'b0; start_i = 1'b0; bif.s_valid = 1'b0; bif.s_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset_and_check();
    mon_en = 1;

    f1 = '{8'h20, 8'h10, 8'h00, 8'h00, 8'h20, 8'h10, 8'h41, 8'h00};
    // 1: basic frame, checksum from the bytes
    run_frame("c1", 8'd2, f1, sum8(f1), 0, -1);
    // 2: same frame, valid every other cycle
    run_frame("c2", 8'd2, f1, sum8(f1), 1, -1);
    // 3: illegal counts
    run_frame("c3a", 8'd0, none, 8'd0, 0, -1);
    run_frame("c3b", 8'(MAX_WORDS + 1), none, 8'd0, 0, -1);
    // 4: bad checksum keeps the old word count, then a good frame recovers
    run_frame("c4a", 8'd2, f1, 8'h85, 0, -1);
    run_frame("c4b", 8'd1, '{8'h11, 8'h22, 8'h33, 8'h44}, 8'hAA, 2, -1);

    // 5: reset after the 5th data byte, then reload from addr 0
    pulse_start();
    wr_addr = 0;
    send_byte(8'd2, 0, 0, 0);
    for (int i = 0; i < 5; i++) send_byte(f1[i], 1, 0, 0);
    @(negedge clk);
    apply_reset_and_check();
    run_frame("c5", 8'd2, f1, sum8(f1), 0, -1);

    // 6: full-size frame of FF with a start pulse mid-data
    ff = {};
    for (int i = 0; i < 4*MAX_WORDS; i++) ff.push_back(8'hFF);
    run_frame("c6", 8'(MAX_WORDS), ff, sum8(ff), 0, 10);
    chk("c6_last_addr", {24'd0, last_addr}, 32'(4*MAX_WORDS - 1));

    // random frames: legal and illegal counts, good and corrupted checksums
    for (int k = 0; k < 14; k++) begin
      n = 8'($urandom_range(0, MAX_WORDS + 2));
      rd = {};
      if (n != 0 && int'(n) <= MAX_WORDS)
        for (int i = 0; i < 4*int'(n); i++) rd.push_back(8'($urandom_range(0, 255)));
      c = sum8(rd);
      if ($urandom_range(0, 2) == 0) c = c + 8'($urandom_range(1, 255));
      run_frame("rnd", n, rd, c, 2, -1);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
